// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel framer: state encoding and the
// bit-count width helper.
package sipo_pkg;

   typedef enum logic {
      ST_SHIFT = 1'b0,
      ST_PAR   = 1'b1
   } state_t;

   // Counter must reach WIDTH while the parity bit is pending, hence +2.
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Shift path of the framer. A clear together with an enable starts a fresh word
// whose first bit is d.
module sipo_shift_reg #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] base;

   assign base = clr ? '0 : q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= (MSB_FIRST != 0) ? {base[WIDTH-2:0], d} : {d, base[WIDTH-1:1]};
      end else if (clr) begin
         q <= '0;
      end
   end

endmodule

// File: rtl/sipo_framer.sv
// Serial-to-parallel framer with holding register and valid/ready handshake.
// Optional parity bit per word when SIPO_PARITY_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_SHIFT | collecting data bits; bit_count = bits accepted so far
// ST_PAR   | all data bits in, waiting for the parity bit (parity only)
module sipo_framer
   import sipo_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           serial_in,
   input  logic                           serial_valid,
   input  logic                           frame_start,
   output logic [WIDTH-1:0]               parallel_out,
   output logic                           parallel_valid,
   input  logic                           parallel_ready,
   output logic [cnt_width(WIDTH)-1:0]    bit_count,
`ifdef SIPO_PARITY_EN
   output logic                           parity_err,
`endif
   output logic                           overrun
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             shift_en, shift_clr, word_done;
   logic [WIDTH-1:0] shift_q, word_c;

   sipo_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk (clk),
      .rst (rst),
      .clr (shift_clr),
      .en  (shift_en),
      .d   (serial_in),
      .q   (shift_q)
   );

`ifdef SIPO_PARITY_EN
   logic parity_bad;

   // Data already sits in the shift register when the parity bit arrives.
   assign word_c     = shift_q;
   assign parity_bad = ((^shift_q) ^ serial_in) != (PARITY_ODD != 0);
`else
   // Word completes on the same edge as its last bit, so assemble it here.
   assign word_c = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], serial_in}
                                    : {serial_in, shift_q[WIDTH-1:1]};
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_en  = 1'b0;
      shift_clr = 1'b0;
      word_done = 1'b0;
      if (frame_start) begin
         shift_clr = 1'b1;
         state_d   = ST_SHIFT;
         if (serial_valid) begin
            shift_en = 1'b1;
            cnt_d    = CNT_W'(1);
         end else begin
            cnt_d = '0;
         end
      end else if (serial_valid) begin
         case (state_q)
            ST_SHIFT: begin
               shift_en = 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                  state_d = ST_PAR;
                  cnt_d   = CNT_W'(WIDTH);
`else
                  word_done = 1'b1;
                  cnt_d     = '0;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
`ifdef SIPO_PARITY_EN
            ST_PAR: begin
               word_done = 1'b1;
               state_d   = ST_SHIFT;
               cnt_d     = '0;
            end
`endif
            default: begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_SHIFT;
         cnt_q          <= '0;
         parallel_out   <= '0;
         parallel_valid <= 1'b0;
         overrun        <= 1'b0;
`ifdef SIPO_PARITY_EN
         parity_err     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
         parity_err <= word_done && parity_bad;
`endif
         if (word_done) begin
            // A held word is only replaced when the consumer takes it this edge.
            if (!parallel_valid || parallel_ready) begin
               parallel_out   <= word_c;
               parallel_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (parallel_valid && parallel_ready) begin
            parallel_valid <= 1'b0;
         end
      end
   end

   assign bit_count = cnt_q;

endmodule

// File: tb/tb_sipo_framer.sv
// Bench for sipo_framer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue-based model of the framing rules.
module tb_sipo_framer;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 2);
`ifdef SIPO_PARITY_EN
   localparam int TGT = W + 1;
`else
   localparam int TGT = W;
`endif

   logic          clk = 1'b0;
   logic          rst, serial_in, serial_valid, frame_start, parallel_ready;
   logic [W-1:0]  out_m, out_l;
   logic          valid_m, valid_l, ovr_m, ovr_l;
   logic [CW-1:0] cnt_m, cnt_l;
`ifdef SIPO_PARITY_EN
   logic          perr_m, perr_l;
`endif

   int vectors = 0;
   int errors  = 0;

   int           bits[$];
   logic [W-1:0] exp_out_m, exp_out_l;
   logic         exp_valid, exp_ovr, exp_perr;

   always #5 clk = ~clk;

   sipo_framer #(.WIDTH(W), .MSB_FIRST(1), .PARITY_ODD(0)) u_msb (
      .clk            (clk),
      .rst            (rst),
      .serial_in      (serial_in),
      .serial_valid   (serial_valid),
      .frame_start    (frame_start),
      .parallel_out   (out_m),
      .parallel_valid (valid_m),
      .parallel_ready (parallel_ready),
      .bit_count      (cnt_m),
`ifdef SIPO_PARITY_EN
      .parity_err     (perr_m),
`endif
      .overrun        (ovr_m)
   );

   sipo_framer #(.WIDTH(W), .MSB_FIRST(0), .PARITY_ODD(0)) u_lsb (
      .clk            (clk),
      .rst            (rst),
      .serial_in      (serial_in),
      .serial_valid   (serial_valid),
      .frame_start    (frame_start),
      .parallel_out   (out_l),
      .parallel_valid (valid_l),
      .parallel_ready (parallel_ready),
      .bit_count      (cnt_l),
`ifdef SIPO_PARITY_EN
      .parity_err     (perr_l),
`endif
      .overrun        (ovr_l)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [W-1:0] pack_word(input bit msb_first);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
         if (msb_first) w[W-1-i] = bits[i][0];
         else           w[i]     = bits[i][0];
      end
      return w;
   endfunction

   task automatic model(input logic r, input logic sv, input logic sin,
                        input logic fs, input logic pr);
      bit           done;
      int           ones;
      logic [W-1:0] wm, wl;
      exp_ovr  = 1'b0;
      exp_perr = 1'b0;
      if (r) begin
         bits.delete();
         exp_out_m = '0;
         exp_out_l = '0;
         exp_valid = 1'b0;
         return;
      end
      done = 1'b0;
      if (fs) bits.delete();
      if (sv) begin
         bits.push_back(int'(sin));
         if (bits.size() == TGT) begin
            wm   = pack_word(1'b1);
            wl   = pack_word(1'b0);
            ones = 0;
            foreach (bits[i]) ones += bits[i];
            if (TGT > W) exp_perr = (ones % 2) != 0;
            bits.delete();
            done = 1'b1;
         end
      end
      if (done) begin
         if (!exp_valid || pr) begin
            exp_out_m = wm;
            exp_out_l = wl;
            exp_valid = 1'b1;
         end else begin
            exp_ovr = 1'b1;
         end
      end else if (exp_valid && pr) begin
         exp_valid = 1'b0;
      end
   endtask

   task automatic cyc(input logic r, input logic sv, input logic sin,
                      input logic fs, input logic pr);
      rst            = r;
      serial_valid   = sv;
      serial_in      = sin;
      frame_start    = fs;
      parallel_ready = pr;
      model(r, sv, sin, fs, pr);
      @(posedge clk);
      #1;
      chk("out_msb",   32'(out_m),   32'(exp_out_m));
      chk("out_lsb",   32'(out_l),   32'(exp_out_l));
      chk("valid_msb", 32'(valid_m), 32'(exp_valid));
      chk("valid_lsb", 32'(valid_l), 32'(exp_valid));
      chk("count",     32'(cnt_m),   32'(bits.size()));
      chk("count_lsb", 32'(cnt_l),   32'(bits.size()));
      chk("overrun",   32'(ovr_m),   32'(exp_ovr));
      chk("overrun_l", 32'(ovr_l),   32'(exp_ovr));
`ifdef SIPO_PARITY_EN
      chk("parity_err", 32'(perr_m), 32'(exp_perr));
`endif
   endtask

   // Bits go out first-bit-first as w[W-1] down to w[0].
   task automatic send_word(input logic [W-1:0] w, input logic pr);
      for (int i = W - 1; i >= 0; i--) cyc(1'b0, 1'b1, w[i], 1'b0, pr);
   endtask

   initial begin
      logic [W-1:0] pat;
      exp_out_m = '0;
      exp_out_l = '0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_perr  = 1'b0;
      rst = 1'b1; serial_in = 1'b0; serial_valid = 1'b0;
      frame_start = 1'b0; parallel_ready = 1'b0;
      #2;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 1);
      chk("reset_out", 32'(out_m), 32'h0);
      chk("reset_cnt", 32'(cnt_m), 32'h0);

      // Basic word, ready held high.
      send_word(8'hA5, 1'b1);
`ifndef SIPO_PARITY_EN
      chk("a5_msb", 32'(out_m), 32'hA5);
      chk("a5_lsb", 32'(out_l), 32'hA5);
      chk("a5_valid", 32'(valid_m), 32'h1);
`endif
      cyc(0, 0, 0, 0, 1);
      chk("a5_valid_drop", 32'(valid_m), 32'h0);

      // 1,1,0,0,0,0,0,0: LSB-first instance sees 0x03.
      send_word(8'hC0, 1'b1);
`ifndef SIPO_PARITY_EN
      chk("c0_msb", 32'(out_m), 32'hC0);
      chk("03_lsb", 32'(out_l), 32'h03);
`endif

      // Valid gated every other cycle.
      pat = 8'h3C;
      for (int i = W - 1; i >= 0; i--) begin
         cyc(0, 1, pat[i], 0, 1);
         cyc(0, 0, ~pat[i], 0, 1);
      end

      // Consumer stalled across two words: second is dropped.
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b0);
`ifndef SIPO_PARITY_EN
      chk("ovr_hold", 32'(out_m), 32'h11);
      chk("ovr_pulse", 32'(ovr_m), 32'h1);
`endif
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("ovr_handshake", 32'(valid_m), 32'h0);

      // Realign after 3 stray bits, then 0xF0.
      cyc(0, 1, 0, 0, 1);
      cyc(0, 1, 1, 0, 1);
      cyc(0, 1, 0, 0, 1);
      pat = 8'hF0;
      cyc(0, 1, pat[W-1], 1, 1);
      chk("realign_cnt", 32'(cnt_m), 32'h1);
      for (int i = W - 2; i >= 0; i--) cyc(0, 1, pat[i], 0, 1);
`ifndef SIPO_PARITY_EN
      chk("f0_msb", 32'(out_m), 32'hF0);
`endif
      // Reset mid-word.
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      chk("rst_mid_out", 32'(out_m), 32'h0);
      chk("rst_mid_valid", 32'(valid_m), 32'h0);
      chk("rst_mid_ovr", 32'(ovr_m), 32'h0);

`ifdef SIPO_PARITY_EN
      send_word(8'h07, 1'b1);
      cyc(0, 1, 1, 0, 1);
      chk("par_ok", 32'(perr_m), 32'h0);
      chk("par_ok_out", 32'(out_m), 32'h07);
      send_word(8'h07, 1'b1);
      cyc(0, 1, 0, 0, 1);
      chk("par_bad", 32'(perr_m), 32'h1);
      // frame_start during PAR discards the word.
      send_word(8'h55, 1'b1);
      cyc(0, 0, 0, 1, 1);
      chk("par_discard", 32'(out_m), 32'h07);
`endif

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(99) == 0, $urandom_range(99) < 75, 1'($urandom_range(1)),
             $urandom_range(99) < 4, $urandom_range(99) < 55);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/sipo_framer.md
SIPO_FRAMER -- requirements
Module: sipo_framer

Interface
REQ-001 Parameter: WIDTH, 8, number of data bits per word (legal range 2..32).
REQ-002 Parameter: MSB_FIRST, 1, 1 = first received bit lands in parallel_out[WIDTH-1]; 0 = first bit lands in parallel_out[0].
REQ-003 Parameter: PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd); ignored otherwise.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: serial_in  input  1  serial data bit.
REQ-007 Port: serial_valid  input  1  serial_in is sampled only when high.
REQ-008 Port: frame_start  input  1  realign; the bit accepted this cycle (if serial_valid) becomes bit 0 of a new word.
REQ-009 Port: parallel_out  output  WIDTH  holding register, the last completed word.
REQ-010 Port: parallel_valid  output  1  holding register contains an unconsumed word.
REQ-011 Port: parallel_ready  input  1  consumer accepts the word when parallel_valid && parallel_ready at a clock edge.
REQ-012 Port: bit_count  output  $clog2(WIDTH+2)  bits of the current word accepted so far.
REQ-013 Port: overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-014 Port: parity_err  output  1  one-cycle pulse with a word whose parity failed (present only with SIPO_PARITY_EN).

Function
REQ-015 States: SHIFT (collecting data bits) and PAR (awaiting parity bit, only with SIPO_PARITY_EN).
REQ-016 In SHIFT, each cycle with serial_valid high shall shift serial_in into the shift register in MSB_FIRST order and increment bit_count.
REQ-017 Cycles with serial_valid low shall change no shift state.
REQ-018 Acceptance of bit WIDTH-1 shall complete the word: without parity, the word loads the holding register at that edge, and parallel_valid is high the following cycle (latency 1 clock from the last bit's sampling edge); bit_count returns to 0.
REQ-019 frame_start with serial_valid shall discard partial bits, and the accepted bit shall be bit 0 (bit_count = 1 afterwards); frame_start without serial_valid shall set bit_count to 0 and the state to SHIFT.
REQ-020 parallel_valid shall stay high and parallel_out stable until a handshake edge; at that edge parallel_valid clears unless a new word completes simultaneously.
REQ-021 Word completion while parallel_valid && !parallel_ready: the word is dropped, the holding register is unchanged, and overrun pulses for 1 cycle.
REQ-022 Word completion on the same edge as a handshake: the new word loads, parallel_valid stays high, and there is no overrun.
REQ-023 Shift register bits not yet written in a word shall not be observable; parallel_out changes only on load.

Reset
REQ-024 When rst is high at a clock edge: parallel_out = 0, parallel_valid = 0, bit_count = 0, overrun = 0, parity_err = 0, state = SHIFT, and the shift register is cleared.
REQ-025 rst mid-word shall discard the partial word and any held word, with no overrun or parity_err pulse.
REQ-026 rst has priority over frame_start, serial_valid, and the handshake.

Configuration
REQ-027 Macro SIPO_PARITY_EN defined: after the WIDTH data bits the state goes to PAR; the next valid bit is parity; the word then completes per REQ-018, REQ-021, and REQ-022, and parity_err pulses with the load if XOR(data, parity) != PARITY_ODD.
REQ-028 With SIPO_PARITY_EN defined, a frame_start during PAR discards the word.
REQ-029 Macro SIPO_PARITY_EN undefined: no PAR state, no parity_err port, and words complete after exactly WIDTH bits.

Structure
REQ-030 Shared package sipo_pkg shall hold the state encoding constants (ST_SHIFT, ST_PAR) and the bit-count width helper.
REQ-031 The sub-module sipo_shift_reg (parameters WIDTH and MSB_FIRST; inputs clk, rst, clr, en, d; output q) shall implement the shift path; sipo_framer holds the FSM, counter, holding register, and handshake.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive valid cycles, parallel_ready=1 -> parallel_out=0xA5 and parallel_valid high for 1 cycle, 1 clock after the 8th bit.
REQ-033 MSB_FIRST=0, same bit sequence -> parallel_out=0xA5 bit-reversed = 0xA5 (symmetric), then sequence 1,1,0,0,0,0,0,0 -> 0x03.
REQ-034 serial_valid gated every other cycle while sending 0x3C -> 0x3C after 16 cycles; bit_count steps 0..7 and then 0.
REQ-035 parallel_ready=0 while two words (0x11, 0x22) are sent -> parallel_out stays 0x11, overrun pulses once at the end of 0x22; raise ready -> handshake and parallel_valid low.
REQ-036 frame_start asserted after 3 bits, then 0xF0 is sent -> parallel_out=0xF0 with no stale bits; rst after 5 bits of the next word -> all outputs 0 and no pulse.
REQ-037 With SIPO_PARITY_EN and PARITY_ODD=0: 0x07 followed by parity 1 -> parity_err=0; 0x07 followed by parity 0 -> parity_err pulses with the load.
